// File: rtl/modn_offset_counter.sv
// Modulo-N time-field counter with a signed one-shot offset handshake, synchronous load,
// and registered carry/borrow pulses. Optional macro MODN_BCD_OUT_EN adds a packed BCD output.
module modn_offset_counter #(
    parameter int MODULUS = 60,
    parameter int WIDTH   = 6,
    parameter int OFS_W   = 7
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_val,
    input  logic                    ofs_valid,
    output logic                    ofs_ready,
    input  logic signed [OFS_W-1:0] ofs,
    output logic [WIDTH-1:0]        value,
    output logic                    carry,
`ifdef MODN_BCD_OUT_EN
    output logic [7:0]              value_bcd,
`endif
    output logic                    borrow
);

    // Sum width covers -(M-1) .. 2M-1 for both value and offset widths.
    localparam int SW = ((WIDTH > OFS_W) ? WIDTH : OFS_W) + 2;
    localparam logic signed [SW-1:0] MOD_S = SW'(MODULUS);
    localparam logic signed [SW-1:0] MAX_S = SW'(MODULUS - 1);

    if ((MODULUS < 2) || (MODULUS > 256)) begin : g_bad_modulus
        $error("modn_offset_counter: MODULUS must be in 2..256");
    end
    if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
        $error("modn_offset_counter: WIDTH too small for MODULUS");
    end
    if ((2 ** (OFS_W - 1)) <= (MODULUS - 1)) begin : g_bad_ofs_w
        $error("modn_offset_counter: OFS_W too small for MODULUS");
    end

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic signed [OFS_W-1:0] held_q, held_d;
    logic [WIDTH-1:0]        value_q, value_d;
    logic                    carry_q, carry_d;
    logic                    borrow_q, borrow_d;

    logic signed [SW-1:0]    value_ext_s;
    logic signed [SW-1:0]    held_ext_s;
    logic signed [SW-1:0]    delta_s;
    logic signed [SW-1:0]    sum_s;
    logic signed [SW-1:0]    load_ext_s;

    function automatic logic signed [OFS_W-1:0] clamp_ofs(input logic signed [OFS_W-1:0] o);
        logic signed [SW-1:0] w;
        w = {{(SW-OFS_W){o[OFS_W-1]}}, o};
        if (w > MAX_S) begin
            return OFS_W'(MAX_S);
        end else if (w < -MAX_S) begin
            return OFS_W'(-MAX_S);
        end else begin
            return o;
        end
    endfunction

    // Next-state, handshake and modular update logic.
    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        value_d     = value_q;
        carry_d     = 1'b0;
        borrow_d    = 1'b0;
        ofs_ready   = (state_q == IDLE) && !load;
        value_ext_s = {{(SW-WIDTH){1'b0}}, value_q};
        held_ext_s  = {{(SW-OFS_W){held_q[OFS_W-1]}}, held_q};
        load_ext_s  = {{(SW-WIDTH){1'b0}}, load_val};
        delta_s     = {{(SW-1){1'b0}}, en};
        if (state_q == PEND) begin
            delta_s = delta_s + held_ext_s;
        end else begin
            delta_s = delta_s;
        end
        sum_s = value_ext_s + delta_s;

        if (load) begin
            // Load wins over en and discards any pending offset.
            value_d = (load_ext_s > MAX_S) ? WIDTH'(MAX_S) : load_val;
            state_d = IDLE;
            held_d  = {OFS_W{1'b0}};
        end else begin
            if (sum_s >= MOD_S) begin
                value_d = WIDTH'(sum_s - MOD_S);
                carry_d = 1'b1;
            end else if (sum_s[SW-1]) begin
                value_d  = WIDTH'(sum_s + MOD_S);
                borrow_d = 1'b1;
            end else begin
                value_d = WIDTH'(sum_s);
            end

            case (state_q)
                IDLE: begin
                    if (ofs_valid) begin
                        held_d  = clamp_ofs(ofs);
                        state_d = PEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PEND:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, offset holding and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            held_q   <= {OFS_W{1'b0}};
            value_q  <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            value_q  <= value_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign value  = value_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;

`ifdef MODN_BCD_OUT_EN
    if (MODULUS > 100) begin : g_bad_bcd
        $error("modn_offset_counter: BCD output requires MODULUS <= 100");
    end

    logic [7:0] bcd_q, bcd_d;

    function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
        int unsigned t;
        t = int'(v);
        return {4'(t / 32'd10), 4'(t % 32'd10)};
    endfunction

    // BCD conversion of the next value so it lands on the same edge.
    always_comb begin
        bcd_d = to_bcd(value_d);
    end

    // BCD output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_q <= 8'h00;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign value_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_modn_offset_counter.sv
// Directed bench for modn_offset_counter: a 60-count field and a 24-count hours field,
// checked every cycle against an arithmetic model plus hand-computed expectations.
module tb_modn_offset_counter;

    logic clk;
    logic reset_n;
    logic en_i [2];
    logic ld_i [2];
    logic [7:0] lv_i [2];
    logic vld_i [2];
    logic signed [6:0] ofs_i [2];

    logic       rdy_a, rdy_b;
    logic [5:0] val_a;
    logic [4:0] val_b;
    logic       car_a, car_b, bor_a, bor_b;
`ifdef MODN_BCD_OUT_EN
    logic [7:0] bcd_a, bcd_b;
`endif

    int errors = 0;
    int checks = 0;

    // Model state
    int m_val [2];
    int m_car [2];
    int m_bor [2];
    int m_pend [2];
    int m_held [2];

    modn_offset_counter #(.MODULUS(60), .WIDTH(6), .OFS_W(7)) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en_i[0]), .load(ld_i[0]),
        .load_val(lv_i[0][5:0]), .ofs_valid(vld_i[0]), .ofs_ready(rdy_a),
        .ofs(ofs_i[0]), .value(val_a), .carry(car_a),
`ifdef MODN_BCD_OUT_EN
        .value_bcd(bcd_a),
`endif
        .borrow(bor_a)
    );

    modn_offset_counter #(.MODULUS(24), .WIDTH(5), .OFS_W(7)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en_i[1]), .load(ld_i[1]),
        .load_val(lv_i[1][4:0]), .ofs_valid(vld_i[1]), .ofs_ready(rdy_b),
        .ofs(ofs_i[1]), .value(val_b), .carry(car_b),
`ifdef MODN_BCD_OUT_EN
        .value_bcd(bcd_b),
`endif
        .borrow(bor_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modulus_of(input int k);
        return (k == 0) ? 60 : 24;
    endfunction

    function automatic int clamp(input int o, input int m);
        if (o > m - 1) return m - 1;
        if (o < -(m - 1)) return -(m - 1);
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: evaluates the field's rules on each rising edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int m, s, acc;
            m = modulus_of(k);
            if (!reset_n) begin
                m_val[k] = 0; m_car[k] = 0; m_bor[k] = 0; m_pend[k] = 0; m_held[k] = 0;
            end else if (ld_i[k]) begin
                m_val[k] = (int'(lv_i[k]) > m - 1) ? m - 1 : int'(lv_i[k]);
                m_car[k] = 0; m_bor[k] = 0; m_pend[k] = 0;
            end else begin
                s = m_val[k] + int'(en_i[k]) + (m_pend[k] != 0 ? m_held[k] : 0);
                m_car[k] = (s >= m) ? 1 : 0;
                m_bor[k] = (s < 0) ? 1 : 0;
                m_val[k] = ((s % m) + m) % m;
                acc = (m_pend[k] == 0 && vld_i[k]) ? 1 : 0;
                if (acc != 0) m_held[k] = clamp(int'(ofs_i[k]), m);
                m_pend[k] = acc;
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(posedge clk) begin
        #1;
        chk("a_value", int'(val_a), m_val[0]);
        chk("a_carry", int'(car_a), m_car[0]);
        chk("a_borrow", int'(bor_a), m_bor[0]);
        chk("a_ready", int'(rdy_a), (m_pend[0] == 0 && !ld_i[0]) ? 1 : 0);
        chk("b_value", int'(val_b), m_val[1]);
        chk("b_carry", int'(car_b), m_car[1]);
        chk("b_borrow", int'(bor_b), m_bor[1]);
        chk("b_ready", int'(rdy_b), (m_pend[1] == 0 && !ld_i[1]) ? 1 : 0);
`ifdef MODN_BCD_OUT_EN
        chk("a_bcd", int'(bcd_a), (m_val[0] / 10) * 16 + (m_val[0] % 10));
        chk("b_bcd", int'(bcd_b), (m_val[1] / 10) * 16 + (m_val[1] % 10));
`endif
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            en_i[k] = 1'b0; ld_i[k] = 1'b0; lv_i[k] = 8'd0; vld_i[k] = 1'b0; ofs_i[k] = 7'sd0;
        end
        step(); step();
        reset_n = 1'b1;
        repeat (5) step();
        chk("rst_value", int'(val_a), 0);
        chk("rst_carry", int'(car_a), 0);
        chk("rst_borrow", int'(bor_a), 0);
        chk("rst_ready", int'(rdy_a), 1);

        // Upward wrap from 58
        ld_i[0] = 1'b1; lv_i[0] = 8'd58; step(); ld_i[0] = 1'b0;
        chk("load58", int'(val_a), 58);
        en_i[0] = 1'b1;
        step(); chk("wrap_59", int'(val_a), 59); chk("wrap_c59", int'(car_a), 0);
        step(); chk("wrap_0", int'(val_a), 0);   chk("wrap_c0", int'(car_a), 1);
        step(); chk("wrap_1", int'(val_a), 1);   chk("wrap_c1", int'(car_a), 0);
        en_i[0] = 1'b0;

        // Negative offset borrow: 3 - 5 -> 58
        ld_i[0] = 1'b1; lv_i[0] = 8'd3; step(); ld_i[0] = 1'b0;
        ofs_i[0] = -7'sd5; vld_i[0] = 1'b1; step(); vld_i[0] = 1'b0;
        chk("neg_ready_low", int'(rdy_a), 0);
        chk("neg_hold3", int'(val_a), 3);
        step();
        chk("neg_value", int'(val_a), 58);
        chk("neg_borrow", int'(bor_a), 1);
        chk("neg_carry", int'(car_a), 0);
        step();
        chk("neg_borrow_end", int'(bor_a), 0);
        chk("neg_ready_back", int'(rdy_a), 1);

        // en plus pending +4 from 57 -> 2 with carry
        ld_i[0] = 1'b1; lv_i[0] = 8'd57; step(); ld_i[0] = 1'b0;
        ofs_i[0] = 7'sd4; vld_i[0] = 1'b1; step();
        vld_i[0] = 1'b0; en_i[0] = 1'b1; step();
        chk("sim_value", int'(val_a), 2);
        chk("sim_carry", int'(car_a), 1);
        en_i[0] = 1'b0;

        // Continuous valid: accepted every other cycle
        ofs_i[0] = 7'sd1; vld_i[0] = 1'b1;
        repeat (6) step();
        vld_i[0] = 1'b0;
        chk("cont_value", int'(val_a), 5);
        step();
        chk("cont_settle", int'(val_a), 5);

        // Load priority and clamp during PEND
        ofs_i[0] = 7'sd7; vld_i[0] = 1'b1; step();
        vld_i[0] = 1'b0; ld_i[0] = 1'b1; lv_i[0] = 8'd63; en_i[0] = 1'b1; step();
        chk("ldp_value", int'(val_a), 59);
        chk("ldp_carry", int'(car_a), 0);
        chk("ldp_ready", int'(rdy_a), 0);
        ld_i[0] = 1'b0; en_i[0] = 1'b0; step();
        chk("ldp_lost", int'(val_a), 59);
        chk("ldp_nocarry", int'(car_a), 0);

        // Offset presented during load is not accepted
        ld_i[0] = 1'b1; lv_i[0] = 8'd5; ofs_i[0] = 7'sd3; vld_i[0] = 1'b1; step();
        ld_i[0] = 1'b0; vld_i[0] = 1'b0; step();
        chk("ld_noacc", int'(val_a), 5);

        // Clamp both extremes
        ofs_i[0] = -7'sd64; vld_i[0] = 1'b1; step(); vld_i[0] = 1'b0; step();
        chk("clamp_neg", int'(val_a), 6);
        chk("clamp_neg_b", int'(bor_a), 1);
        ofs_i[0] = 7'sd63; vld_i[0] = 1'b1; step(); vld_i[0] = 1'b0; step();
        chk("clamp_pos", int'(val_a), 5);
        chk("clamp_pos_c", int'(car_a), 1);

        // Reset during PEND drops the offset
        ofs_i[0] = 7'sd10; vld_i[0] = 1'b1; step(); vld_i[0] = 1'b0;
        reset_n = 1'b0; #3;
        chk("rstp_value", int'(val_a), 0);
        chk("rstp_ready", int'(rdy_a), 1);
        step(); reset_n = 1'b1; step();
        chk("rstp_after", int'(val_a), 0);

        // Hours field: 23 + clamp(30) -> 22 with carry
        ld_i[1] = 1'b1; lv_i[1] = 8'd23; step(); ld_i[1] = 1'b0;
        ofs_i[1] = 7'sd30; vld_i[1] = 1'b1; step(); vld_i[1] = 1'b0; step();
        chk("hr_value", int'(val_b), 22);
        chk("hr_carry", int'(car_b), 1);
`ifdef MODN_BCD_OUT_EN
        chk("hr_bcd", int'(bcd_b), 8'h22);
`endif

        // Free run across several wraps of both fields
        en_i[0] = 1'b1; en_i[1] = 1'b1;
        repeat (70) step();
        en_i[0] = 1'b0; en_i[1] = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modn_offset_counter.md
Name: modn_offset_counter

Overview:
- Parametrised modulo-N time-field counter; successor to the fixed minutes counter. One instance covers seconds, minutes, hours, or a zone-adjusted field.
- Adds a signed one-shot offset over a valid/ready handshake, true modular wrap in both directions, and synchronous load.
- Registered carry and borrow pulses cascade into the next field (seconds -> minutes -> hours).

Parameters:
- MODULUS, 60, count range 0..MODULUS-1; legal values 2..256.
- WIDTH, 6, width of value/load_val; must satisfy 2^WIDTH >= MODULUS.
- OFS_W, 7, width of the signed two's-complement offset; must satisfy 2^(OFS_W-1) > MODULUS-1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  advance by +1 this cycle (tick from the lower field's carry).
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  load value.
- ofs_valid  input  1  offset request valid.
- ofs_ready  output  1  offset request accepted when high together with ofs_valid.
- ofs  input  OFS_W  signed offset, held stable while ofs_valid is high.
- value  output  WIDTH  current count.
- carry  output  1  one-cycle pulse: this update wrapped upward.
- borrow  output  1  one-cycle pulse: this update wrapped downward.

Behaviour:
- Reset (reset_n low, asynchronous): value=0, carry=0, borrow=0, FSM=IDLE, ofs_ready=1, offset holding register cleared.
- FSM IDLE: ofs_ready=1. When ofs_valid is high, clamp ofs to [-(MODULUS-1), +(MODULUS-1)] and latch it into the holding register. Next state is PEND.
- FSM PEND: ofs_ready=0. The held offset is applied in this cycle's update. Next state is IDLE, so the maximum accept rate is one offset every 2 cycles.
- Update every cycle: d = (en ? 1 : 0) + (state==PEND ? held : 0), signed. s = value + d, computed at width >= WIDTH+2 signed, giving range -(M-1)..2M-1.
- If s >= MODULUS: value <= s-MODULUS, carry <= 1.
- If s < 0: value <= s+MODULUS, borrow <= 1.
- Otherwise: value <= s, carry <= 0, borrow <= 0.
- Result: at most one wrap per update; carry and borrow are never both 1.
- carry/borrow are registered and change on the same edge as value. Latency from en to new value is 1 cycle. From offset acceptance to the offset appearing in value is 2 edges.
- en=1 with d=+1 at value=MODULUS-1 gives value=0 and carry=1. en=0 with d=0 holds value, carry=0, borrow=0.
- en together with PEND: both are summed in one update (e.g. +1 and -5 give a net -4).
- load=1 has top priority: value <= min(load_val, MODULUS-1), carry=0, borrow=0. Any PEND offset is discarded, FSM goes to IDLE, and en is ignored that cycle. An ofs_valid arriving in a load cycle is not accepted; ofs_ready is forced to 0 during load.
- reset_n asserted mid-PEND drops the pending offset.
- Out-of-range ofs (e.g. +100 with MODULUS=60) is clamped to +59, never wrapped twice.

Optional Feature:
- Macro MODN_BCD_OUT_EN.
- Defined: adds output value_bcd [7:0], the registered packed BCD of value (tens in [7:4], ones in [3:0]), updated on the same edge as value. Reset value 8'h00. Requires MODULUS <= 100; elaboration error otherwise.
- Undefined: port and logic absent; the remaining behaviour is identical.

Test Plan:
- Reset/hold: release reset_n with en=0 for 5 cycles -> value=0, carry=0, borrow=0, ofs_ready=1.
- Upward wrap: MODULUS=60, load 58, then en=1 for 3 cycles -> value 59, 0, 1; carry high only on the edge producing 0.
- Negative offset borrow: value=3, ofs=-5 with ofs_valid for 1 cycle -> ofs_ready drops for 1 cycle; value=58 two edges after acceptance; borrow pulses once; carry stays 0.
- Simultaneous en+offset: value=57, en=1 and a PEND offset of +4 in the same cycle -> value=2, carry=1. ofs_valid held high continuously -> accepted only every other cycle.
- Load priority/clamp: load=1, load_val=63, en=1 during PEND -> value=59, pending offset lost, FSM=IDLE, no carry.
- Hours config with MODN_BCD_OUT_EN: MODULUS=24, value=23, ofs=+30 -> clamped to +23, value=22, carry=1, value_bcd=8'h22.
